lfsr_stream: RTL and testbench

//   Parametrised Fibonacci LFSR pseudo-random generator with a valid/ready output stream.

---
 rtl/lfsr_pkg.sv | 51 +++++
 rtl/lfsr_stream_if.sv | 23 ++
 rtl/lfsr_period_cnt.sv | 40 ++++
 rtl/lfsr_stream_chk.sv | 21 ++
 rtl/lfsr_stream.sv | 100 ++++++++++
 tb/tb_lfsr_stream.sv | 235 +++++++++++++++++++++++
 6 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: width limits, maximal-length tap masks for widths 2..32,
// and the Fibonacci next-state helper used by lfsr_stream.
package lfsr_pkg;

   localparam int LFSR_MIN_WIDTH = 2;
   localparam int LFSR_MAX_WIDTH = 32;

   // Bit i of a mask selects state[i] into the feedback XOR.
   localparam logic [1:0]  LFSR_TAPS_2  = 2'h3;
   localparam logic [2:0]  LFSR_TAPS_3  = 3'b110;
   localparam logic [3:0]  LFSR_TAPS_4  = 4'hC;
   localparam logic [4:0]  LFSR_TAPS_5  = 5'h14;
   localparam logic [5:0]  LFSR_TAPS_6  = 6'h30;
   localparam logic [6:0]  LFSR_TAPS_7  = 7'h60;
   localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
   localparam logic [8:0]  LFSR_TAPS_9  = 9'h110;
   localparam logic [9:0]  LFSR_TAPS_10 = 10'h240;
   localparam logic [10:0] LFSR_TAPS_11 = 11'h500;
   localparam logic [11:0] LFSR_TAPS_12 = 12'h829;
   localparam logic [12:0] LFSR_TAPS_13 = 13'h100D;
   localparam logic [13:0] LFSR_TAPS_14 = 14'h2015;
   localparam logic [14:0] LFSR_TAPS_15 = 15'h6000;
   localparam logic [15:0] LFSR_TAPS_16 = 16'hD008;
   localparam logic [16:0] LFSR_TAPS_17 = 17'h12000;
   localparam logic [17:0] LFSR_TAPS_18 = 18'h20400;
   localparam logic [18:0] LFSR_TAPS_19 = 19'h40023;
   localparam logic [19:0] LFSR_TAPS_20 = 20'h90000;
   localparam logic [20:0] LFSR_TAPS_21 = 21'h140000;
   localparam logic [21:0] LFSR_TAPS_22 = 22'h300000;
   localparam logic [22:0] LFSR_TAPS_23 = 23'h420000;
   localparam logic [23:0] LFSR_TAPS_24 = 24'hE10000;
   localparam logic [24:0] LFSR_TAPS_25 = 25'h1200000;
   localparam logic [25:0] LFSR_TAPS_26 = 26'h2000023;
   localparam logic [26:0] LFSR_TAPS_27 = 27'h4000013;
   localparam logic [27:0] LFSR_TAPS_28 = 28'h9000000;
   localparam logic [28:0] LFSR_TAPS_29 = 29'h14000000;
   localparam logic [29:0] LFSR_TAPS_30 = 30'h20000029;
   localparam logic [30:0] LFSR_TAPS_31 = 31'h48000000;
   localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;

   // Callers zero-extend state/taps and truncate the result back to their width.
   function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_next(
      input logic [LFSR_MAX_WIDTH-1:0] state,
      input logic [LFSR_MAX_WIDTH-1:0] taps
   );
      logic fb;
      fb = ^(state & taps);
      return {state[LFSR_MAX_WIDTH-2:0], fb};
   endfunction

endpackage

// File: rtl/lfsr_stream_if.sv
// Valid/ready output stream carrying LFSR words from the generator (master)
// to its consumer (slave).
interface lfsr_stream_if #(
   parameter int WIDTH = 3
) ();

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;

   modport master (
      output out_valid,
      output out,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out,
      output out_ready
   );

endinterface

// File: rtl/lfsr_period_cnt.sv
// Period tracker for lfsr_stream: counts accepted steps since the reference seed
// and captures the count when the sequence returns to it.
module lfsr_period_cnt #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst_syn,
   input  logic             accept,
   input  logic             match,
   input  logic             clr,
   output logic             wrap,
   output logic [WIDTH-1:0] period
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] step_cnt_r;

   // A seed load restarts the count but keeps the last measured period visible.
   always_ff @(posedge clk) begin
      if (rst_syn) begin
         step_cnt_r <= {WIDTH{1'b0}};
         period     <= {WIDTH{1'b0}};
         wrap       <= 1'b0;
      end else if (clr) begin
         step_cnt_r <= {WIDTH{1'b0}};
         wrap       <= 1'b0;
      end else if (accept && match) begin
         step_cnt_r <= {WIDTH{1'b0}};
         period     <= step_cnt_r + ONE;
         wrap       <= 1'b1;
      end else if (accept) begin
         step_cnt_r <= step_cnt_r + ONE;
         wrap       <= 1'b0;
      end else begin
         wrap       <= 1'b0;
      end
   end

endmodule

// File: rtl/lfsr_stream_chk.sv
// Elaboration-constant sanity checks on lfsr_stream parameters, evaluated in simulation.
module lfsr_stream_chk
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 3,
   parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_3,
   parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input logic clk
);

   always @(posedge clk) begin
      assert (WIDTH >= LFSR_MIN_WIDTH && WIDTH <= LFSR_MAX_WIDTH)
         else $error("lfsr_stream: WIDTH %0d out of range", WIDTH);
      assert (TAPS[WIDTH-1] == 1'b1)
         else $error("lfsr_stream: TAPS must include the top state bit");
      assert (SEED != {WIDTH{1'b0}})
         else $error("lfsr_stream: SEED must be non-zero");
   end

endmodule

// File: rtl/lfsr_stream.sv
// Fibonacci LFSR generator with a valid/ready output stream, run-time seed load and
// period measurement. Define LFSR_LOCKUP_RECOVER_EN to replace an all-zero load with SEED.
module lfsr_stream
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 3,
   parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_3,
   parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic               clk,
   input  logic               rst_syn,
   input  logic               en,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_seed,
   lfsr_stream_if.master      stream,
   output logic               wrap,
   output logic [WIDTH-1:0]   period,
   output logic               lockup
);

   logic [WIDTH-1:0] state_r;
   logic [WIDTH-1:0] ref_seed_r;
   logic             valid_r;
   logic [WIDTH-1:0] next_s;
   logic [WIDTH-1:0] seed_eff_s;
   logic             accept_s;
   logic             match_s;

   assign accept_s = valid_r & stream.out_ready;
   assign next_s   = WIDTH'(lfsr_next(LFSR_MAX_WIDTH'(state_r), LFSR_MAX_WIDTH'(TAPS)));
   assign match_s  = (next_s == ref_seed_r);

   assign stream.out       = state_r;
   assign stream.out_valid = valid_r;

`ifdef LFSR_LOCKUP_RECOVER_EN
   always_comb begin
      seed_eff_s = load_seed;
      if (load_seed == {WIDTH{1'b0}}) begin
         seed_eff_s = SEED;
      end else begin
         seed_eff_s = load_seed;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_syn) begin
         lockup <= 1'b0;
      end else begin
         lockup <= load & (load_seed == {WIDTH{1'b0}});
      end
   end
`else
   assign seed_eff_s = load_seed;
   assign lockup     = 1'b0;
`endif

   // Once offered, a word stays valid until taken; en only matters when nothing is pending.
   always_ff @(posedge clk) begin
      if (rst_syn) begin
         state_r    <= SEED;
         ref_seed_r <= SEED;
         valid_r    <= 1'b0;
      end else if (load) begin
         state_r    <= seed_eff_s;
         ref_seed_r <= seed_eff_s;
         valid_r    <= 1'b0;
      end else begin
         if (accept_s) begin
            state_r <= next_s;
         end
         if (valid_r && !accept_s) begin
            valid_r <= 1'b1;
         end else begin
            valid_r <= en;
         end
      end
   end

   lfsr_period_cnt #(
      .WIDTH (WIDTH)
   ) u_period_cnt (
      .clk     (clk),
      .rst_syn (rst_syn),
      .accept  (accept_s),
      .match   (match_s),
      .clr     (load),
      .wrap    (wrap),
      .period  (period)
   );

   lfsr_stream_chk #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED)
   ) u_chk (
      .clk (clk)
   );

endmodule

// File: tb/tb_lfsr_stream.sv
// Self-checking bench for lfsr_stream: a 3-bit and an 8-bit instance share one clock;
// expected words are queued from the bench's own sequence/model and popped on each accept.
module tb_lfsr_stream;
   import lfsr_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_rst, a_en, a_load, a_wrap, a_lockup;
   logic [2:0] a_seed, a_period;
   logic       b_rst, b_en, b_load, b_wrap, b_lockup;
   logic [7:0] b_seed, b_period;

   lfsr_stream_if #(.WIDTH(3)) a_if ();
   lfsr_stream_if #(.WIDTH(8)) b_if ();

   lfsr_stream #(.WIDTH(3), .TAPS(LFSR_TAPS_3), .SEED(3'b001)) u_a (
      .clk(clk), .rst_syn(a_rst), .en(a_en), .load(a_load), .load_seed(a_seed),
      .stream(a_if), .wrap(a_wrap), .period(a_period), .lockup(a_lockup));

   lfsr_stream #(.WIDTH(8), .TAPS(LFSR_TAPS_8), .SEED(8'h01)) u_b (
      .clk(clk), .rst_syn(b_rst), .en(b_en), .load(b_load), .load_seed(b_seed),
      .stream(b_if), .wrap(b_wrap), .period(b_period), .lockup(b_lockup));

   int chk_cnt = 0;
   int pass_cnt = 0;
   logic [7:0] exp_q[$];

   function automatic logic [7:0] m8_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   task automatic test_reset();
      a_rst = 1'b1; a_en = 1'b0; a_load = 1'b0; a_seed = 3'b000; a_if.out_ready = 1'b0;
      b_rst = 1'b1; b_en = 1'b0; b_load = 1'b0; b_seed = 8'h00; b_if.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk_cnt++; if (a_if.out !== 3'b001) $display("FAIL reset_out: got %b want 001", a_if.out); else pass_cnt++;
      chk_cnt++; if (a_if.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", a_if.out_valid); else pass_cnt++;
      chk_cnt++; if (a_wrap !== 1'b0) $display("FAIL reset_wrap: got %b want 0", a_wrap); else pass_cnt++;
      chk_cnt++; if (a_period !== 3'd0) $display("FAIL reset_period: got %0d want 0", a_period); else pass_cnt++;
      chk_cnt++; if (a_lockup !== 1'b0) $display("FAIL reset_lockup: got %b want 0", a_lockup); else pass_cnt++;
      chk_cnt++; if (b_if.out !== 8'h01) $display("FAIL reset_out8: got %h want 01", b_if.out); else pass_cnt++;
      chk_cnt++; if (b_if.out_valid !== 1'b0) $display("FAIL reset_valid8: got %b want 0", b_if.out_valid); else pass_cnt++;
      chk_cnt++; if (b_lockup !== 1'b0) $display("FAIL reset_lockup8: got %b want 0", b_lockup); else pass_cnt++;
      a_rst = 1'b0; b_rst = 1'b0;
   endtask

   task automatic test_free_run();
      logic [2:0] seq [8] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b001};
      logic [7:0] e;
      int acc = 0;
      int n = 0;
      logic exp_wrap = 1'b0;
      foreach (seq[i]) exp_q.push_back({5'b00000, seq[i]});
      a_en = 1'b1; a_if.out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk); n++;
         if (n == 1) begin
            chk_cnt++; if (a_if.out_valid !== 1'b1) $display("FAIL run_latency: valid %b want 1", a_if.out_valid); else pass_cnt++;
         end
         chk_cnt++; if (a_wrap !== exp_wrap) $display("FAIL run_wrap@%0d: got %b want %b", n, a_wrap, exp_wrap); else pass_cnt++;
         exp_wrap = 1'b0;
         if (a_if.out_valid && a_if.out_ready) begin
            e = exp_q.pop_front(); acc++;
            chk_cnt++; if (a_if.out !== e[2:0]) $display("FAIL run_out#%0d: got %b want %b", acc, a_if.out, e[2:0]); else pass_cnt++;
            if (acc == 7) exp_wrap = 1'b1;
         end
      end
      chk_cnt++; if (exp_q.size() != 0) $display("FAIL run_timeout: %0d words left want 0", exp_q.size()); else pass_cnt++;
      exp_q.delete();
      @(negedge clk);
      chk_cnt++; if (a_period !== 3'd7) $display("FAIL run_period: got %0d want 7", a_period); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      int n = 0;
      while (!(a_if.out_valid === 1'b1 && a_if.out === 3'b101) && n < 16) begin
         @(negedge clk); n++;
      end
      a_if.out_ready = 1'b0;
      chk_cnt++; if (a_if.out !== 3'b101) $display("FAIL stall_reach: got %b want 101", a_if.out); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) a_en = 1'b0;
         chk_cnt++; if (a_if.out_valid !== 1'b1) $display("FAIL stall_valid%0d: got %b want 1", i, a_if.out_valid); else pass_cnt++;
         chk_cnt++; if (a_if.out !== 3'b101) $display("FAIL stall_out%0d: got %b want 101", i, a_if.out); else pass_cnt++;
         if (i == 3) a_if.out_ready = 1'b1;
      end
      @(negedge clk);
      chk_cnt++; if (a_if.out_valid !== 1'b0) $display("FAIL stall_release_valid: got %b want 0", a_if.out_valid); else pass_cnt++;
      chk_cnt++; if (a_if.out !== 3'b011) $display("FAIL stall_release_out: got %b want 011", a_if.out); else pass_cnt++;
      a_en = 1'b1;
   endtask

   task automatic test_load();
      logic [2:0] seq [8] = '{3'b111, 3'b110, 3'b100, 3'b001, 3'b010, 3'b101, 3'b011, 3'b111};
      logic [7:0] e;
      int acc = 0;
      int n = 0;
      logic exp_wrap = 1'b0;
      @(negedge clk);
      chk_cnt++; if (a_if.out_valid !== 1'b1) $display("FAIL load_pre_valid: got %b want 1", a_if.out_valid); else pass_cnt++;
      a_load = 1'b1; a_seed = 3'b111;
      @(negedge clk);
      a_load = 1'b0;
      chk_cnt++; if (a_if.out_valid !== 1'b0) $display("FAIL load_valid: got %b want 0", a_if.out_valid); else pass_cnt++;
      chk_cnt++; if (a_if.out !== 3'b111) $display("FAIL load_out: got %b want 111", a_if.out); else pass_cnt++;
      chk_cnt++; if (a_wrap !== 1'b0) $display("FAIL load_wrap: got %b want 0", a_wrap); else pass_cnt++;
      foreach (seq[i]) exp_q.push_back({5'b00000, seq[i]});
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk); n++;
         chk_cnt++; if (a_wrap !== exp_wrap) $display("FAIL load_wrap@%0d: got %b want %b", n, a_wrap, exp_wrap); else pass_cnt++;
         exp_wrap = 1'b0;
         if (a_if.out_valid && a_if.out_ready) begin
            e = exp_q.pop_front(); acc++;
            chk_cnt++; if (a_if.out !== e[2:0]) $display("FAIL load_out#%0d: got %b want %b", acc, a_if.out, e[2:0]); else pass_cnt++;
            if (acc == 7) exp_wrap = 1'b1;
         end
      end
      chk_cnt++; if (exp_q.size() != 0) $display("FAIL load_timeout: %0d words left want 0", exp_q.size()); else pass_cnt++;
      exp_q.delete();
      @(negedge clk);
      chk_cnt++; if (a_period !== 3'd7) $display("FAIL load_period: got %0d want 7", a_period); else pass_cnt++;
   endtask

   task automatic test_zero_seed();
      logic exp_wrap = 1'b0;
      int acc = 0;
      a_load = 1'b1; a_seed = 3'b000;
      @(negedge clk);
      a_load = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
      chk_cnt++; if (a_if.out !== 3'b001) $display("FAIL zero_recover_out: got %b want 001", a_if.out); else pass_cnt++;
      chk_cnt++; if (a_lockup !== 1'b1) $display("FAIL zero_lockup: got %b want 1", a_lockup); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (a_lockup !== 1'b0) $display("FAIL zero_lockup_end: got %b want 0", a_lockup); else pass_cnt++;
      chk_cnt++; if (a_if.out === 3'b000) $display("FAIL zero_state: got %b want non-zero", a_if.out); else pass_cnt++;
`else
      chk_cnt++; if (a_if.out !== 3'b000) $display("FAIL zero_out: got %b want 000", a_if.out); else pass_cnt++;
      chk_cnt++; if (a_if.out_valid !== 1'b0) $display("FAIL zero_valid: got %b want 0", a_if.out_valid); else pass_cnt++;
      chk_cnt++; if (a_lockup !== 1'b0) $display("FAIL zero_lockup: got %b want 0", a_lockup); else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk_cnt++; if (a_wrap !== exp_wrap) $display("FAIL zero_wrap@%0d: got %b want %b", i, a_wrap, exp_wrap); else pass_cnt++;
         exp_wrap = 1'b0;
         if (a_if.out_valid && a_if.out_ready) begin
            acc++; exp_wrap = 1'b1;
            chk_cnt++; if (a_if.out !== 3'b000) $display("FAIL zero_acc_out%0d: got %b want 000", i, a_if.out); else pass_cnt++;
         end
      end
      chk_cnt++; if (acc < 3) $display("FAIL zero_accepts: got %0d want >=3", acc); else pass_cnt++;
      chk_cnt++; if (a_period !== 3'd1) $display("FAIL zero_period: got %0d want 1", a_period); else pass_cnt++;
`endif
   endtask

   task automatic test_reset_mid();
      int n = 0;
      int acc = 0;
      logic got = 1'b0;
      a_if.out_ready = 1'b0; a_en = 1'b1;
      while (a_if.out_valid !== 1'b1 && n < 8) begin
         @(negedge clk); n++;
      end
      repeat (2) @(negedge clk);
      chk_cnt++; if (a_if.out_valid !== 1'b1) $display("FAIL rst_stall_valid: got %b want 1", a_if.out_valid); else pass_cnt++;
      a_rst = 1'b1; a_load = 1'b1; a_seed = 3'b111;
      @(negedge clk);
      a_rst = 1'b0; a_load = 1'b0;
      chk_cnt++; if (a_if.out !== 3'b001) $display("FAIL rst_mid_out: got %b want 001", a_if.out); else pass_cnt++;
      chk_cnt++; if (a_if.out_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", a_if.out_valid); else pass_cnt++;
      chk_cnt++; if (a_period !== 3'd0) $display("FAIL rst_mid_period: got %0d want 0", a_period); else pass_cnt++;
      chk_cnt++; if (a_wrap !== 1'b0) $display("FAIL rst_mid_wrap: got %b want 0", a_wrap); else pass_cnt++;
      a_if.out_ready = 1'b1; n = 0;
      while (!got && n < 20) begin
         @(negedge clk); n++;
         if (a_wrap === 1'b1) got = 1'b1;
         else if (a_if.out_valid && a_if.out_ready) acc++;
      end
      chk_cnt++; if (acc != 7) $display("FAIL rst_restart_accepts: got %0d want 7", acc); else pass_cnt++;
      chk_cnt++; if (a_period !== 3'd7) $display("FAIL rst_restart_period: got %0d want 7", a_period); else pass_cnt++;
      a_en = 1'b0;
   endtask

   task automatic test_width8();
      logic [7:0] s = 8'h01;
      logic [7:0] e;
      int acc = 0;
      int n = 0;
      logic exp_wrap = 1'b0;
      logic seen_zero = 1'b0;
      for (int i = 0; i < 255; i++) begin
         exp_q.push_back(s);
         s = m8_next(s);
      end
      b_en = 1'b1; b_if.out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk); n++;
         chk_cnt++; if (b_wrap !== exp_wrap) $display("FAIL w8_wrap@%0d: got %b want %b", n, b_wrap, exp_wrap); else pass_cnt++;
         exp_wrap = 1'b0;
         if (b_if.out_valid && b_if.out_ready) begin
            e = exp_q.pop_front(); acc++;
            if (b_if.out === 8'h00) seen_zero = 1'b1;
            chk_cnt++; if (b_if.out !== e) $display("FAIL w8_out#%0d: got %h want %h", acc, b_if.out, e); else pass_cnt++;
            if (acc == 255) exp_wrap = 1'b1;
         end
      end
      chk_cnt++; if (exp_q.size() != 0) $display("FAIL w8_timeout: %0d words left want 0", exp_q.size()); else pass_cnt++;
      exp_q.delete();
      @(negedge clk);
      chk_cnt++; if (b_wrap !== 1'b1) $display("FAIL w8_final_wrap: got %b want 1", b_wrap); else pass_cnt++;
      chk_cnt++; if (b_period !== 8'd255) $display("FAIL w8_period: got %0d want 255", b_period); else pass_cnt++;
      chk_cnt++; if (b_if.out !== 8'h01) $display("FAIL w8_return: got %h want 01", b_if.out); else pass_cnt++;
      chk_cnt++; if (seen_zero !== 1'b0) $display("FAIL w8_zero_seen: got %b want 0", seen_zero); else pass_cnt++;
      b_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_backpressure();
      test_load();
      test_zero_seed();
      test_reset_mid();
      test_width8();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
